// File: rtl/rgb2gray_pkg.sv
// Shared types and constants for the RGB-to-gray streaming block.
// The optional statistics outputs are enabled by defining RGB2GRAY_STATS_EN.
package rgb2gray_pkg;

  typedef enum logic [1:0] {
    RGB_IDLE  = 2'd0,
    RGB_RUN   = 2'd1,
    RGB_DRAIN = 2'd2,
    RGB_DONE  = 2'd3
  } rgb_state_e;

  // BT.601-style luma weights scaled so that they sum to 128 (SHIFT = 7)
  localparam int unsigned COEF_R_DEF   = 38;
  localparam int unsigned COEF_G_DEF   = 75;
  localparam int unsigned COEF_B_DEF   = 15;
  localparam int unsigned COEF_SUM_DEF = COEF_R_DEF + COEF_G_DEF + COEF_B_DEF;

  // Width of r*cr + g*cg + b*cb without overflow (three terms need 2 extra bits)
  function automatic int unsigned mac_sum_width(input int unsigned pix_w, input int unsigned coef_w);
    return pix_w + coef_w + 2;
  endfunction

endpackage

// File: rtl/rgb2gray_stream_if.sv
// Pixel stream bundle: colour input handshake plus gray output with its metadata.
// slave = the converter's view, master = the environment driving/consuming it.
interface rgb2gray_stream_if #(
  parameter int PIX_W  = 8,
  parameter int DIM_W  = 16,
  parameter int ADDR_W = 32
);
  logic              s_valid;
  logic              s_ready;
  logic [PIX_W-1:0]  s_r;
  logic [PIX_W-1:0]  s_g;
  logic [PIX_W-1:0]  s_b;

  logic              m_valid;
  logic              m_ready;
  logic [PIX_W-1:0]  m_data;
  logic [ADDR_W-1:0] m_addr;
  logic [DIM_W-1:0]  m_x;
  logic [DIM_W-1:0]  m_y;
  logic              m_eol;
  logic              m_last;

  modport slave (
    input  s_valid, s_r, s_g, s_b, m_ready,
    output s_ready, m_valid, m_data, m_addr, m_x, m_y, m_eol, m_last
  );

  modport master (
    output s_valid, s_r, s_g, s_b, m_ready,
    input  s_ready, m_valid, m_data, m_addr, m_x, m_y, m_eol, m_last
  );
endinterface

// File: rtl/rgb2gray_stream_mac.sv
// gray_mac: two-stage weighted-sum pipeline (products, then sum/shift/saturate).
// A side-band tag travels with each pixel; the whole pipe freezes while stall=1.
module gray_mac
  import rgb2gray_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int COEF_W = 8,
  parameter int SHIFT  = 7,
  parameter int TAG_W  = 8
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              stall,
  input  logic              in_valid,
  input  logic [PIX_W-1:0]  in_r,
  input  logic [PIX_W-1:0]  in_g,
  input  logic [PIX_W-1:0]  in_b,
  input  logic [COEF_W-1:0] coef_r,
  input  logic [COEF_W-1:0] coef_g,
  input  logic [COEF_W-1:0] coef_b,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  output logic [PIX_W-1:0]  out_data,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int PROD_W = PIX_W + COEF_W;
  localparam int SUM_W  = int'(mac_sum_width(PIX_W, COEF_W));
  localparam logic [PIX_W-1:0] PIX_MAX = '1;

  logic [PIX_W-1:0]  pix  [3];
  logic [COEF_W-1:0] coef [3];

  assign pix[0]  = in_r;
  assign pix[1]  = in_g;
  assign pix[2]  = in_b;
  assign coef[0] = coef_r;
  assign coef[1] = coef_g;
  assign coef[2] = coef_b;

  // Stage 1: one product register per colour channel
  genvar gi;
  generate
    for (gi = 0; gi < 3; gi++) begin : g_ch
      logic [PROD_W-1:0] prod_q;
      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          prod_q <= '0;
        end else if (!stall && in_valid) begin
          prod_q <= PROD_W'(pix[gi]) * PROD_W'(coef[gi]);
        end
      end
    end
  endgenerate

  logic             v1_q;
  logic [TAG_W-1:0] tag1_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1_q   <= 1'b0;
      tag1_q <= '0;
    end else if (!stall) begin
      v1_q <= in_valid;
      if (in_valid) begin
        tag1_q <= in_tag;
      end
    end
  end

  // Stage 2: sum, scale down and clamp to the pixel range
  logic [SUM_W-1:0] sum_d;
  logic [SUM_W-1:0] shifted_d;
  logic [PIX_W-1:0] gray_d;

  always_comb begin
    sum_d     = SUM_W'(g_ch[0].prod_q) + SUM_W'(g_ch[1].prod_q) + SUM_W'(g_ch[2].prod_q);
    shifted_d = sum_d >> SHIFT;
    gray_d    = PIX_W'(shifted_d);
    if (shifted_d > SUM_W'(PIX_MAX)) begin
      gray_d = PIX_MAX;
    end
  end

  logic             v2_q;
  logic [PIX_W-1:0] data2_q;
  logic [TAG_W-1:0] tag2_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v2_q    <= 1'b0;
      data2_q <= '0;
      tag2_q  <= '0;
    end else if (!stall) begin
      v2_q <= v1_q;
      if (v1_q) begin
        data2_q <= gray_d;
        tag2_q  <= tag1_q;
      end
    end
  end

  assign out_valid = v2_q;
  assign out_data  = data2_q;
  assign out_tag   = tag2_q;

endmodule

// File: rtl/rgb2gray_stream.sv
// Frame-oriented RGB-to-gray converter: sequences W*H pixels through gray_mac and
// tags each with x/y/address. Define RGB2GRAY_STATS_EN for min/max/sum outputs.
module rgb2gray_stream
  import rgb2gray_pkg::*;
#(
  parameter int PIX_W  = 8,
  parameter int COEF_W = 8,
  parameter int SHIFT  = 7,
  parameter int DIM_W  = 16,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              start,
  input  logic [DIM_W-1:0]  frame_w,
  input  logic [DIM_W-1:0]  frame_h,
  input  logic [COEF_W-1:0] coef_r,
  input  logic [COEF_W-1:0] coef_g,
  input  logic [COEF_W-1:0] coef_b,
  rgb2gray_stream_if.slave  px,
  output logic              busy,
  output logic              done
`ifdef RGB2GRAY_STATS_EN
  ,
  output logic [PIX_W-1:0]        stat_min,
  output logic [PIX_W-1:0]        stat_max,
  output logic [ADDR_W+PIX_W-1:0] stat_sum
`endif
);

  localparam logic [1:0] ST_IDLE  = RGB_IDLE;
  localparam logic [1:0] ST_RUN   = RGB_RUN;
  localparam logic [1:0] ST_DRAIN = RGB_DRAIN;
  localparam logic [1:0] ST_DONE  = RGB_DONE;

  localparam int CNT_W = 2 * DIM_W;
  localparam int TAG_W = ADDR_W + 2 * DIM_W + 2;

  logic [1:0]        state_q, state_d;
  logic [DIM_W-1:0]  w_q;
  logic [CNT_W-1:0]  total_q;
  logic [COEF_W-1:0] cr_q, cg_q, cb_q;
  logic [CNT_W-1:0]  in_cnt_q;
  logic [DIM_W-1:0]  x_q, y_q;

  logic start_ok, dims_ok, stall, s_ready_int, in_fire, out_fire;
  logic eol_in, last_in;

  assign start_ok = (state_q == ST_IDLE) && start;
  assign dims_ok  = (frame_w != '0) && (frame_h != '0);
  assign stall    = px.m_valid && !px.m_ready;
  assign out_fire = px.m_valid && px.m_ready;

  assign s_ready_int = (state_q == ST_RUN) && (in_cnt_q < total_q) && !stall;
  assign in_fire     = px.s_valid && s_ready_int;
  assign px.s_ready  = s_ready_int;

  assign eol_in  = (x_q == w_q - DIM_W'(1));
  assign last_in = (in_cnt_q == total_q - CNT_W'(1));

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:  if (start) state_d = dims_ok ? ST_RUN : ST_DONE;
      ST_RUN:   if (in_fire && last_in) state_d = ST_DRAIN;
      ST_DRAIN: if (out_fire && px.m_last) state_d = ST_DONE;
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Frame parameters are captured once per accepted start
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      w_q     <= '0;
      total_q <= '0;
      cr_q    <= '0;
      cg_q    <= '0;
      cb_q    <= '0;
    end else if (start_ok) begin
      w_q     <= frame_w;
      total_q <= CNT_W'(frame_w) * CNT_W'(frame_h);
      cr_q    <= coef_r;
      cg_q    <= coef_g;
      cb_q    <= coef_b;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      in_cnt_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
    end else if (start_ok) begin
      in_cnt_q <= '0;
      x_q      <= '0;
      y_q      <= '0;
    end else if (in_fire) begin
      in_cnt_q <= in_cnt_q + CNT_W'(1);
      if (eol_in) begin
        x_q <= '0;
        y_q <= y_q + DIM_W'(1);
      end else begin
        x_q <= x_q + DIM_W'(1);
      end
    end
  end

  logic [TAG_W-1:0] tag_in, tag_out;
  logic             mac_valid;
  logic [PIX_W-1:0] mac_data;

  assign tag_in = {ADDR_W'(in_cnt_q), x_q, y_q, eol_in, last_in};

  gray_mac #(
    .PIX_W  (PIX_W),
    .COEF_W (COEF_W),
    .SHIFT  (SHIFT),
    .TAG_W  (TAG_W)
  ) u_mac (
    .clk       (clk),
    .rstn      (rstn),
    .stall     (stall),
    .in_valid  (in_fire),
    .in_r      (px.s_r),
    .in_g      (px.s_g),
    .in_b      (px.s_b),
    .coef_r    (cr_q),
    .coef_g    (cg_q),
    .coef_b    (cb_q),
    .in_tag    (tag_in),
    .out_valid (mac_valid),
    .out_data  (mac_data),
    .out_tag   (tag_out)
  );

  assign px.m_valid = mac_valid;
  assign px.m_data  = mac_data;
  assign {px.m_addr, px.m_x, px.m_y, px.m_eol, px.m_last} = tag_out;

  assign busy = (state_q == ST_RUN) || (state_q == ST_DRAIN);
  assign done = (state_q == ST_DONE);

`ifdef RGB2GRAY_STATS_EN
  logic [PIX_W-1:0]        stat_min_q, stat_max_q;
  logic [ADDR_W+PIX_W-1:0] stat_sum_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      stat_min_q <= '1;
      stat_max_q <= '0;
      stat_sum_q <= '0;
    end else if (start_ok) begin
      stat_min_q <= '1;
      stat_max_q <= '0;
      stat_sum_q <= '0;
    end else if (out_fire) begin
      if (px.m_data < stat_min_q) stat_min_q <= px.m_data;
      if (px.m_data > stat_max_q) stat_max_q <= px.m_data;
      stat_sum_q <= stat_sum_q + (ADDR_W + PIX_W)'(px.m_data);
    end
  end

  assign stat_min = stat_min_q;
  assign stat_max = stat_max_q;
  assign stat_sum = stat_sum_q;
`endif

endmodule

// File: tb/tb_rgb2gray_stream.sv
// Randomized self-checking bench for rgb2gray_stream against an index-based frame model.
module tb_rgb2gray_stream;
  import rgb2gray_pkg::*;

  localparam int PIX_W  = 8;
  localparam int COEF_W = 8;
  localparam int SHIFT  = 7;
  localparam int DIM_W  = 16;
  localparam int ADDR_W = 32;

  logic              clk = 1'b0;
  logic              rstn = 1'b0;
  logic              start = 1'b0;
  logic [DIM_W-1:0]  frame_w = '0;
  logic [DIM_W-1:0]  frame_h = '0;
  logic [COEF_W-1:0] coef_r = '0;
  logic [COEF_W-1:0] coef_g = '0;
  logic [COEF_W-1:0] coef_b = '0;
  logic              busy;
  logic              done;
`ifdef RGB2GRAY_STATS_EN
  logic [PIX_W-1:0]        stat_min;
  logic [PIX_W-1:0]        stat_max;
  logic [ADDR_W+PIX_W-1:0] stat_sum;
`endif

  rgb2gray_stream_if #(.PIX_W(PIX_W), .DIM_W(DIM_W), .ADDR_W(ADDR_W)) px_if ();

  rgb2gray_stream #(
    .PIX_W(PIX_W), .COEF_W(COEF_W), .SHIFT(SHIFT), .DIM_W(DIM_W), .ADDR_W(ADDR_W)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .start   (start),
    .frame_w (frame_w),
    .frame_h (frame_h),
    .coef_r  (coef_r),
    .coef_g  (coef_g),
    .coef_b  (coef_b),
    .px      (px_if),
    .busy    (busy),
    .done    (done)
`ifdef RGB2GRAY_STATS_EN
    ,
    .stat_min(stat_min),
    .stat_max(stat_max),
    .stat_sum(stat_sum)
`endif
  );

  initial forever #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  initial forever @(posedge clk) cyc++;

  typedef struct {
    int data;
    int addr;
    int x;
    int y;
    int eol;
    int last;
  } exp_t;

  exp_t exp_q[$];

  int cur_w, cur_h, cur_cr, cur_cg, cur_cb;
  int sent, outs;
  int first_acc_cyc, first_val_cyc, last_xfer_cyc, last_data;
  bit mon_en = 1'b0;
  int ready_mode = 0;
  int pat_idx = 0;

  task automatic check_val(input string tag, input longint got, input longint expv);
    checks++;
    if (got !== expv) begin
      errors++;
      $display("FAIL %s got=%0d exp=%0d (t=%0t)", tag, got, expv, $time);
    end
  endtask

  // Reference: weighted sum with plain integers, scaled and clamped
  function automatic int model_gray(input int r, input int g, input int b);
    int s;
    s = (r * cur_cr + g * cur_cg + b * cur_cb) >> SHIFT;
    return (s > 255) ? 255 : s;
  endfunction

  // Output sink: chooses m_ready each cycle and scores every transfer
  initial begin : sink
    bit prev_stall = 1'b0;
    int held_data = 0;
    int held_addr = 0;
    bit [3:0] pat = 4'b1001;
    bit rdy;
    exp_t e;
    px_if.m_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (!mon_en) begin
        px_if.m_ready = 1'b1;
        prev_stall = 1'b0;
        continue;
      end
      case (ready_mode)
        0:       rdy = 1'b1;
        1:       rdy = ($urandom_range(0, 3) != 0);
        default: begin rdy = pat[3 - (pat_idx % 4)]; pat_idx++; end
      endcase
      px_if.m_ready = rdy;
      #1;
      if (prev_stall) begin
        check_val("stall_valid", px_if.m_valid, 1);
        check_val("stall_data", px_if.m_data, held_data);
        check_val("stall_addr", px_if.m_addr, held_addr);
      end
      if (px_if.m_valid && first_val_cyc < 0) first_val_cyc = cyc;
      if (px_if.m_valid && px_if.m_ready) begin
        if (exp_q.size() == 0) begin
          check_val("extra_out", exp_q.size(), 1);
        end else begin
          e = exp_q.pop_front();
          check_val("data", px_if.m_data, e.data);
          check_val("addr", px_if.m_addr, e.addr);
          check_val("x", px_if.m_x, e.x);
          check_val("y", px_if.m_y, e.y);
          check_val("eol", px_if.m_eol, e.eol);
          check_val("last", px_if.m_last, e.last);
          $display("OUT addr=%0d x=%0d y=%0d data=%0d eol=%0d last=%0d",
                   px_if.m_addr, px_if.m_x, px_if.m_y, px_if.m_data, px_if.m_eol, px_if.m_last);
        end
        outs++;
        last_xfer_cyc = cyc;
        last_data = int'(px_if.m_data);
      end
      prev_stall = px_if.m_valid && !px_if.m_ready;
      held_data = int'(px_if.m_data);
      held_addr = int'(px_if.m_addr);
    end
  end

  task automatic begin_frame(input int w, input int h, input int cr, input int cg, input int cb);
    cur_w = w; cur_h = h; cur_cr = cr; cur_cg = cg; cur_cb = cb;
    sent = 0; outs = 0;
    first_acc_cyc = -1; first_val_cyc = -1; last_xfer_cyc = -1;
    @(negedge clk);
    start = 1'b1;
    frame_w = DIM_W'(w); frame_h = DIM_W'(h);
    coef_r = COEF_W'(cr); coef_g = COEF_W'(cg); coef_b = COEF_W'(cb);
    @(negedge clk);
    start = 1'b0;
    frame_w = '0; frame_h = '0;
  endtask

  task automatic send_pixel(input int r, input int g, input int b);
    bit acc = 1'b0;
    int budget = 0;
    exp_t e;
    while (!acc) begin
      @(negedge clk);
      px_if.s_valid = 1'b1;
      px_if.s_r = PIX_W'(r); px_if.s_g = PIX_W'(g); px_if.s_b = PIX_W'(b);
      #1;
      acc = px_if.s_ready;
      if (acc) begin
        e.data = model_gray(r, g, b);
        e.addr = sent;
        e.x = sent % cur_w;
        e.y = sent / cur_w;
        e.eol = (e.x == cur_w - 1);
        e.last = (sent == cur_w * cur_h - 1);
        exp_q.push_back(e);
        if (sent == 0) first_acc_cyc = cyc;
        sent++;
      end else begin
        budget++;
        if (budget > 200) begin
          check_val("s_ready_timeout", acc, 1);
          break;
        end
      end
    end
  endtask

  task automatic idle_input();
    @(negedge clk);
    px_if.s_valid = 1'b0;
  endtask

  // pmode 0: fixed pixel (fr,fg,fb); pmode 1: random pixels with random gaps
  task automatic run_frame(input int w, input int h, input int cr, input int cg, input int cb,
                           input int pmode, input int fr, input int fg, input int fb);
    int done_cyc = -1;
    begin_frame(w, h, cr, cg, cb);
    check_val("busy_run", busy, 1);
    for (int i = 0; i < w * h; i++) begin
      if (pmode == 0) begin
        send_pixel(fr, fg, fb);
      end else begin
        if ($urandom_range(0, 3) == 0) idle_input();
        send_pixel($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
      end
    end
    idle_input();
    for (int k = 0; k < 300; k++) begin
      #1;
      if (done) begin done_cyc = cyc; break; end
      @(negedge clk);
    end
    check_val("done_seen", (done_cyc >= 0), 1);
    check_val("done_after_last", done_cyc - last_xfer_cyc, 1);
    check_val("busy_at_done", busy, 0);
    check_val("out_count", outs, w * h);
    check_val("queue_empty", exp_q.size(), 0);
    check_val("latency", first_val_cyc - first_acc_cyc, 2);
    @(negedge clk);
    #1;
    check_val("done_pulse_width", done, 0);
    $display("FRAME %0dx%0d coef=%0d/%0d/%0d outputs=%0d", w, h, cr, cg, cb, outs);
  endtask

  // Zero-size frame: start cycle, then a single DONE cycle, never busy, no pixels
  task automatic zero_frame(input int w, input int h);
    begin_frame(w, h, COEF_R_DEF, COEF_G_DEF, COEF_B_DEF);
    #1;
    check_val("zero_done", done, 1);
    check_val("zero_busy", busy, 0);
    check_val("zero_mvalid", px_if.m_valid, 0);
    @(negedge clk);
    #1;
    check_val("zero_done_clear", done, 0);
    check_val("zero_busy_after", busy, 0);
    check_val("zero_outs", outs, 0);
    $display("ZERO FRAME %0dx%0d done pulse checked", w, h);
  endtask

  task automatic check_reset_values(input string pfx);
    check_val({pfx, "_s_ready"}, px_if.s_ready, 0);
    check_val({pfx, "_m_valid"}, px_if.m_valid, 0);
    check_val({pfx, "_m_data"}, px_if.m_data, 0);
    check_val({pfx, "_m_addr"}, px_if.m_addr, 0);
    check_val({pfx, "_m_x"}, px_if.m_x, 0);
    check_val({pfx, "_m_y"}, px_if.m_y, 0);
    check_val({pfx, "_m_eol"}, px_if.m_eol, 0);
    check_val({pfx, "_m_last"}, px_if.m_last, 0);
    check_val({pfx, "_busy"}, busy, 0);
    check_val({pfx, "_done"}, done, 0);
  endtask

  initial begin : main
    px_if.s_valid = 1'b0;
    px_if.s_r = '0; px_if.s_g = '0; px_if.s_b = '0;
    repeat (2) @(negedge clk);
    #1;
    check_reset_values("rst");
    @(negedge clk);
    rstn = 1'b1;
    mon_en = 1'b1;

    ready_mode = 0;
    run_frame(4, 2, COEF_R_DEF, COEF_G_DEF, COEF_B_DEF, 0, 255, 255, 255);
    check_val("white_data", last_data, 255);

    run_frame(1, 1, COEF_R_DEF, COEF_G_DEF, COEF_B_DEF, 0, 100, 50, 200);
    check_val("example_82", last_data, 82);

    run_frame(1, 1, 100, 100, 100, 0, 255, 255, 255);
    check_val("saturate_255", last_data, 255);

    ready_mode = 2;
    pat_idx = 0;
    run_frame(3, 3, COEF_R_DEF, COEF_G_DEF, COEF_B_DEF, 1, 0, 0, 0);

    zero_frame(0, 5);
    zero_frame(3, 0);

    ready_mode = 1;
    for (int f = 0; f < 4; f++) begin
      run_frame($urandom_range(1, 5), $urandom_range(1, 4), $urandom_range(0, 255),
                $urandom_range(0, 255), $urandom_range(0, 255), 1, 0, 0, 0);
    end

    // Mid-frame reset: 5 of 16 pixels in flight, then a clean full frame
    ready_mode = 0;
    begin_frame(4, 4, COEF_R_DEF, COEF_G_DEF, COEF_B_DEF);
    for (int i = 0; i < 5; i++) send_pixel($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255));
    idle_input();
    #3;
    mon_en = 1'b0;
    rstn = 1'b0;
    #1;
    check_reset_values("midrst");
    exp_q.delete();
    repeat (2) @(negedge clk);
    rstn = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check_val("post_rst_busy", busy, 0);
    check_val("post_rst_mvalid", px_if.m_valid, 0);
    check_val("post_rst_sready", px_if.s_ready, 0);
    mon_en = 1'b1;
    run_frame(4, 4, COEF_R_DEF, COEF_G_DEF, COEF_B_DEF, 1, 0, 0, 0);

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
